multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter: none; all encodings come from the shared package.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port: rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port: opc  input  6  opcode from the held instruction register.
REQ-005 SHALL have port: func  input  6  R-type function field from the held instruction register.
REQ-006 SHALL have port: zero  input  1  ALU zero flag from the datapath.
REQ-007 SHALL have port: IRWrite  output  1  instruction register load enable.
REQ-008 SHALL have port: PCWrite  output  1  PC load enable.
REQ-009 SHALL have port: PCSrc  output  2  next-PC select: 00 PC+4, 01 branch target, 10 jump target, 11 rs.
REQ-010 SHALL have port: RegDst  output  2  write-register select: 00 rt, 01 rd, 10 $31.
REQ-011 SHALL have port: WDInp  output  1  write-data select: 0 ALU/memory, 1 PC+4.
REQ-012 SHALL have port: RegWrite, ALUSrc, MemRead, MemWrite, MemToReg  output  1 each  datapath controls, same meaning as the single-cycle datapath.
REQ-013 SHALL have port: ALUOperation  output  3  codes: 000 and, 001 or, 010 add, 110 sub, 111 slt.
REQ-014 SHALL have port: done  output  1  one-cycle pulse in the final state of each instruction.

Function
REQ-015 SHALL implement a Moore FSM with states FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, JAL, JR, WB_R, WB_I.
REQ-016 SHALL drive every output to 0 in any state that does not assert it.
REQ-017 In FETCH, SHALL assert IRWrite and go to DECODE.
REQ-018 In DECODE, SHALL route on opc as follows: 000000 with func 001000 goes to JR; other 000000 goes to EXEC_R; 001000 (addi) and 001010 (slti) go to EXEC_I; 100011 and 101011 go to MEM_ADDR; 000100 goes to BRANCH; 000010 goes to JUMP; 000011 goes to JAL; any other value goes to FETCH with no write enable asserted.
REQ-019 In EXEC_R, SHALL set ALUSrc=0 and ALUOperation from func (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, any other value add), then go to WB_R.
REQ-020 In WB_R, SHALL hold the EXEC_R ALU controls and assert RegDst=01, MemToReg=0, RegWrite, PCWrite with PCSrc=00, and done; then go to FETCH.
REQ-021 In EXEC_I, SHALL set ALUSrc=1 and ALUOperation=010 for addi or 111 for slti, then go to WB_I.
REQ-022 In WB_I, SHALL hold the EXEC_I controls and assert RegDst=00, RegWrite, PCWrite with PCSrc=00, and done.
REQ-023 In MEM_ADDR, SHALL set ALUSrc=1 and ALUOperation=010, then go to MEM_RD for lw or MEM_WR for sw.
REQ-024 MEM_RD, MEM_WB and MEM_WR SHALL keep ALUSrc=1 and ALUOperation=010.
REQ-025 MEM_RD SHALL assert MemRead and go to MEM_WB.
REQ-026 MEM_WB SHALL assert MemRead, MemToReg=1, RegDst=00, RegWrite, PCWrite with PCSrc=00, and done.
REQ-027 MEM_WR SHALL assert MemWrite, PCWrite with PCSrc=00, and done.
REQ-028 In BRANCH, SHALL set ALUSrc=0, ALUOperation=110, PCWrite, and done, with PCSrc=01 if zero=1 else 00.
REQ-029 JUMP SHALL assert PCWrite with PCSrc=10 and done.
REQ-030 JAL SHALL assert PCWrite with PCSrc=10, RegDst=10, WDInp=1, RegWrite, and done.
REQ-031 JR SHALL assert PCWrite with PCSrc=11 and done.
REQ-032 PCWrite SHALL be asserted exactly once per legal instruction, only in its final state.
REQ-033 Latencies including FETCH SHALL be: beq, j, jal and jr 3 cycles; R-type, addi, slti and sw 4 cycles; lw 5 cycles.
REQ-034 An illegal opcode SHALL consume 2 cycles, assert no PCWrite, RegWrite or MemWrite, and leave done=0.
REQ-035 The datapath cannot advance past an illegal opcode; recovery is by reset only.

Reset
REQ-036 rst=1 at a clock edge SHALL force FETCH in any state, including mid-instruction, with no further write enables in that instruction.
REQ-037 While rst=1, all outputs SHALL be 0.
REQ-038 On the first edge after rst deasserts, SHALL perform the FETCH action.

Structure
REQ-039 A shared package SHALL hold the opcode and func constants, the ALUOperation, PCSrc and RegDst encodings, and the state enum.
REQ-040 One combinational sub-module, alu_op_decoder, SHALL map (state class, opc, func) to ALUOperation.

Verification
REQ-041 Reset, then opc=000000, func=100010: FETCH, DECODE, EXEC_R, WB_R; ALUOperation=110; RegWrite, PCWrite and done high only in cycle 4; RegDst=01.
REQ-042 opc=100011: 5 cycles; MemRead high in cycles 4-5; RegWrite, MemToReg and PCWrite high only in cycle 5.
REQ-043 opc=000100 with zero=1, then again with zero=0: cycle 3 PCSrc=01 for zero=1 and 00 for zero=0; PCWrite=1 in both cases.
REQ-044 opc=000011: cycle 3 has RegDst=10, WDInp=1, RegWrite=1, PCSrc=10.
REQ-045 opc=000000, func=001000: cycle 3 PCSrc=11, RegWrite=0.
REQ-046 opc=111111, then rst asserted in MEM_RD of a later lw: FETCH, DECODE, FETCH with no writes; the rst edge returns to FETCH with all outputs 0.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle controller:
// opcodes, function codes, mux selects and the FSM state set.
package multicycle_controller_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;
  localparam logic [1:0] PC_RS  = 2'b11;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_BRANCH,
    S_JUMP,
    S_JAL,
    S_JR,
    S_WB_R,
    S_WB_I
  } state_t;

  typedef enum logic [2:0] {
    AC_NONE,
    AC_RTYPE,
    AC_ITYPE,
    AC_MEM,
    AC_BRANCH
  } alu_class_t;

  // Groups states by which ALU operation they drive.
  function automatic alu_class_t alu_class(
    input state_t s
  );
    case (s)
      S_EXEC_R, S_WB_R:     return AC_RTYPE;
      S_EXEC_I, S_WB_I:     return AC_ITYPE;
      S_MEM_ADDR, S_MEM_RD,
      S_MEM_WB, S_MEM_WR:   return AC_MEM;
      S_BRANCH:             return AC_BRANCH;
      default:              return AC_NONE;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_op_decoder.sv
// ALU operation decode from state class,
// opcode and R-type function field.
module alu_op_decoder
  import multicycle_controller_pkg::*;
(
  input  alu_class_t  cls,
  input  logic [5:0]  opc,
  input  logic [5:0]  func,
  output logic [2:0]  alu_op
);

  // Pick the ALU code for the current state class.
  always_comb begin
    alu_op = ALU_AND;
    case (cls)
      AC_RTYPE: begin
        unique case (1'b1)
          (func == FN_SUB): alu_op = ALU_SUB;
          (func == FN_AND): alu_op = ALU_AND;
          (func == FN_OR):  alu_op = ALU_OR;
          (func == FN_SLT): alu_op = ALU_SLT;
          default:          alu_op = ALU_ADD;
        endcase
      end
      AC_ITYPE:
        alu_op = (opc == OP_SLTI) ? ALU_SLT
                                  : ALU_ADD;
      AC_MEM:    alu_op = ALU_ADD;
      AC_BRANCH: alu_op = ALU_SUB;
      default:   alu_op = ALU_AND;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing a multicycle MIPS-style
// datapath; outputs forced low while rst is high.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opc,
  input  logic [5:0] func,
  input  logic       zero,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic [1:0] PCSrc,
  output logic [1:0] RegDst,
  output logic       WDInp,
  output logic       RegWrite,
  output logic       ALUSrc,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemToReg,
  output logic [2:0] ALUOperation,
  output logic       done
);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] alu_op;

  alu_op_decoder u_alu_dec (
    .cls    (alu_class(state)),
    .opc    (opc),
    .func   (func),
    .alu_op (alu_op)
  );

  // State register with synchronous reset to FETCH.
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  // Next-state sequencing; DECODE routes on opcode.
  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH: state_nxt = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          (opc == OP_RTYPE && func == FN_JR):
            state_nxt = S_JR;
          (opc == OP_RTYPE && func != FN_JR):
            state_nxt = S_EXEC_R;
          (opc == OP_ADDI), (opc == OP_SLTI):
            state_nxt = S_EXEC_I;
          (opc == OP_LW), (opc == OP_SW):
            state_nxt = S_MEM_ADDR;
          (opc == OP_BEQ): state_nxt = S_BRANCH;
          (opc == OP_J):   state_nxt = S_JUMP;
          (opc == OP_JAL): state_nxt = S_JAL;
          default:         state_nxt = S_FETCH;
        endcase
      end
      S_EXEC_R:   state_nxt = S_WB_R;
      S_EXEC_I:   state_nxt = S_WB_I;
      S_MEM_ADDR:
        state_nxt = (opc == OP_SW) ? S_MEM_WR
                                   : S_MEM_RD;
      S_MEM_RD:   state_nxt = S_MEM_WB;
      default:    state_nxt = S_FETCH;
    endcase
  end

  // Per-state outputs; everything low during reset.
  always_comb begin
    IRWrite      = 1'b0;
    PCWrite      = 1'b0;
    PCSrc        = PC_SEQ;
    RegDst       = RD_RT;
    WDInp        = 1'b0;
    RegWrite     = 1'b0;
    ALUSrc       = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    MemToReg     = 1'b0;
    ALUOperation = ALU_AND;
    done         = 1'b0;
    if (!rst) begin
      ALUOperation = alu_op;
      case (state)
        S_FETCH: IRWrite = 1'b1;
        S_WB_R: begin
          RegDst   = RD_RD;
          RegWrite = 1'b1;
          PCWrite  = 1'b1;
          done     = 1'b1;
        end
        S_EXEC_I, S_MEM_ADDR:
          ALUSrc = 1'b1;
        S_WB_I: begin
          ALUSrc   = 1'b1;
          RegWrite = 1'b1;
          PCWrite  = 1'b1;
          done     = 1'b1;
        end
        S_MEM_RD: begin
          ALUSrc  = 1'b1;
          MemRead = 1'b1;
        end
        S_MEM_WB: begin
          ALUSrc   = 1'b1;
          MemRead  = 1'b1;
          MemToReg = 1'b1;
          RegWrite = 1'b1;
          PCWrite  = 1'b1;
          done     = 1'b1;
        end
        S_MEM_WR: begin
          ALUSrc   = 1'b1;
          MemWrite = 1'b1;
          PCWrite  = 1'b1;
          done     = 1'b1;
        end
        S_BRANCH: begin
          PCSrc   = zero ? PC_BR : PC_SEQ;
          PCWrite = 1'b1;
          done    = 1'b1;
        end
        S_JUMP: begin
          PCSrc   = PC_JMP;
          PCWrite = 1'b1;
          done    = 1'b1;
        end
        S_JAL: begin
          PCSrc    = PC_JMP;
          RegDst   = RD_RA;
          WDInp    = 1'b1;
          RegWrite = 1'b1;
          PCWrite  = 1'b1;
          done     = 1'b1;
        end
        S_JR: begin
          PCSrc   = PC_RS;
          PCWrite = 1'b1;
          done    = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller:
// per-cycle expected output words queued, checked at negedge.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opc;
  logic [5:0] func;
  logic       zero;
  logic       IRWrite, PCWrite, WDInp, RegWrite;
  logic       ALUSrc, MemRead, MemWrite, MemToReg;
  logic       done;
  logic [1:0] PCSrc, RegDst;
  logic [2:0] ALUOperation;

  multicycle_controller dut (
    .clk          (clk),
    .rst          (rst),
    .opc          (opc),
    .func         (func),
    .zero         (zero),
    .IRWrite      (IRWrite),
    .PCWrite      (PCWrite),
    .PCSrc        (PCSrc),
    .RegDst       (RegDst),
    .WDInp        (WDInp),
    .RegWrite     (RegWrite),
    .ALUSrc       (ALUSrc),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .MemToReg     (MemToReg),
    .ALUOperation (ALUOperation),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] val;
  } item_t;

  item_t sb[$];
  int    total = 0;
  int    bad   = 0;

  logic [15:0] act;
  assign act = {IRWrite, PCWrite, PCSrc, RegDst,
                WDInp, RegWrite, ALUSrc, MemRead,
                MemWrite, MemToReg, ALUOperation,
                done};

  // Arg order matches the packing of act above.
  function automatic logic [15:0] v(
    input int ir, input int pw, input int pcs,
    input int rd, input int wd, input int rw,
    input int as, input int mr, input int mw,
    input int m2r, input int aop, input int dn
  );
    return {ir[0], pw[0], pcs[1:0], rd[1:0],
            wd[0], rw[0], as[0], mr[0], mw[0],
            m2r[0], aop[2:0], dn[0]};
  endfunction

  task automatic exp_c(input string n,
                       input logic [15:0] x);
    item_t it;
    it.name = n;
    it.val  = x;
    sb.push_back(it);
  endtask

  task automatic issue(input logic [5:0] o,
                       input logic [5:0] f,
                       input logic z);
    opc  = o;
    func = f;
    zero = z;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      item_t it;
      it = sb.pop_front();
      total++;
      if (act !== it.val) begin
        bad++;
        $display("FAIL %s: got %h want %h",
                 it.name, act, it.val);
      end
    end
  end

  logic [15:0] F, Z;

  initial begin
    F = v(1,0,0,0,0,0,0,0,0,0,0,0);
    Z = v(0,0,0,0,0,0,0,0,0,0,0,0);
    rst = 1'b1;
    issue(6'b000000, 6'b000000, 1'b0);
    @(posedge clk); #1;
    exp_c("rst_a", Z);
    step(1);
    issue(6'b100011, 6'b000000, 1'b0);
    exp_c("rst_b", Z);
    step(1);
    rst = 1'b0;

    issue(6'b000000, 6'b100010, 1'b0);
    exp_c("sub_f", F);
    exp_c("sub_d", Z);
    exp_c("sub_ex", v(0,0,0,0,0,0,0,0,0,0,6,0));
    exp_c("sub_wb", v(0,1,0,1,0,1,0,0,0,0,6,1));
    step(4);

    issue(6'b000000, 6'b100100, 1'b0);
    exp_c("and_f", F);
    exp_c("and_d", Z);
    exp_c("and_ex", v(0,0,0,0,0,0,0,0,0,0,0,0));
    exp_c("and_wb", v(0,1,0,1,0,1,0,0,0,0,0,1));
    step(4);

    issue(6'b000000, 6'b000011, 1'b0);
    exp_c("unk_f", F);
    exp_c("unk_d", Z);
    exp_c("unk_ex", v(0,0,0,0,0,0,0,0,0,0,2,0));
    exp_c("unk_wb", v(0,1,0,1,0,1,0,0,0,0,2,1));
    step(4);

    issue(6'b001010, 6'b000000, 1'b0);
    exp_c("slti_f", F);
    exp_c("slti_d", Z);
    exp_c("slti_ex", v(0,0,0,0,0,0,1,0,0,0,7,0));
    exp_c("slti_wb", v(0,1,0,0,0,1,1,0,0,0,7,1));
    step(4);

    issue(6'b001000, 6'b000000, 1'b0);
    exp_c("addi_f", F);
    exp_c("addi_d", Z);
    exp_c("addi_ex", v(0,0,0,0,0,0,1,0,0,0,2,0));
    exp_c("addi_wb", v(0,1,0,0,0,1,1,0,0,0,2,1));
    step(4);

    issue(6'b100011, 6'b000000, 1'b0);
    exp_c("lw_f", F);
    exp_c("lw_d", Z);
    exp_c("lw_ad", v(0,0,0,0,0,0,1,0,0,0,2,0));
    exp_c("lw_rd", v(0,0,0,0,0,0,1,1,0,0,2,0));
    exp_c("lw_wb", v(0,1,0,0,0,1,1,1,0,1,2,1));
    step(5);

    issue(6'b101011, 6'b000000, 1'b0);
    exp_c("sw_f", F);
    exp_c("sw_d", Z);
    exp_c("sw_ad", v(0,0,0,0,0,0,1,0,0,0,2,0));
    exp_c("sw_wr", v(0,1,0,0,0,0,1,0,1,0,2,1));
    step(4);

    issue(6'b000100, 6'b000000, 1'b1);
    exp_c("beq1_f", F);
    exp_c("beq1_d", Z);
    exp_c("beq1_b", v(0,1,1,0,0,0,0,0,0,0,6,1));
    step(3);

    issue(6'b000100, 6'b000000, 1'b0);
    exp_c("beq0_f", F);
    exp_c("beq0_d", Z);
    exp_c("beq0_b", v(0,1,0,0,0,0,0,0,0,0,6,1));
    step(3);

    issue(6'b000010, 6'b000000, 1'b0);
    exp_c("j_f", F);
    exp_c("j_d", Z);
    exp_c("j_x", v(0,1,2,0,0,0,0,0,0,0,0,1));
    step(3);

    issue(6'b000011, 6'b000000, 1'b0);
    exp_c("jal_f", F);
    exp_c("jal_d", Z);
    exp_c("jal_x", v(0,1,2,2,1,1,0,0,0,0,0,1));
    step(3);

    issue(6'b000000, 6'b001000, 1'b0);
    exp_c("jr_f", F);
    exp_c("jr_d", Z);
    exp_c("jr_x", v(0,1,3,0,0,0,0,0,0,0,0,1));
    step(3);

    issue(6'b111111, 6'b000000, 1'b0);
    exp_c("ill_f0", F);
    exp_c("ill_d0", Z);
    exp_c("ill_f1", F);
    exp_c("ill_d1", Z);
    step(4);

    rst = 1'b1;
    exp_c("ill_rst", Z);
    step(1);
    rst = 1'b0;

    issue(6'b100011, 6'b000000, 1'b0);
    exp_c("lwr_f", F);
    exp_c("lwr_d", Z);
    exp_c("lwr_ad", v(0,0,0,0,0,0,1,0,0,0,2,0));
    step(3);
    rst = 1'b1;
    exp_c("lwr_rst", Z);
    step(1);
    rst = 1'b0;

    issue(6'b000010, 6'b000000, 1'b0);
    exp_c("post_f", F);
    exp_c("post_d", Z);
    exp_c("post_x", v(0,1,2,0,0,0,0,0,0,0,0,1));
    step(3);

    for (int i = 0; i < 10; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: left %0d want 0",
               sb.size());
    end
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got stall want finish");
    $fatal(1);
  end

endmodule
